gpio_input_controller: RTL and testbench



---
 rtl/gpio_input_controller.sv | 147 ++++++++++++++
 tb/tb_gpio_input_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_controller.sv
// GPIO input controller: per-pin 2-flop synchroniser, polarity inversion,
// counter-based debounce, edge detection, write-1-to-clear pending flags and
// a registered level interrupt. Registers are read with combinational rdata.
module gpio_input_controller #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] state_o,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] AddrInvert  = 2'd0;
  localparam logic [1:0] AddrState   = 2'd1;
  localparam logic [1:0] AddrEdgeEn  = 2'd2;
  localparam logic [1:0] AddrPending = 2'd3;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] invert_q, invert_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             irq_q;

  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] rise_evt, fall_evt;
  logic [WIDTH-1:0] pend_set, pend_clr;
  logic             wr_invert, wr_edge_en, wr_pending;

  // Only the low bits of each field exist; the rest of wdata is dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pin_in;
      s2_q <= s1_q;
    end
  end

  // Debounce: a pin must disagree with stable for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    cand     = s2_q ^ invert_q;
    stable_d = stable_q;
    rise_evt = '0;
    fall_evt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (cand[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = cand[i];
          rise_evt[i] = cand[i];
          fall_evt[i] = ~cand[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state: stable value and per-pin mismatch counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Register write decode and pending update; a set beats a same-cycle clear.
  always_comb begin
    wr_invert  = wr_en && (addr == AddrInvert);
    wr_edge_en = wr_en && (addr == AddrEdgeEn);
    wr_pending = wr_en && (addr == AddrPending);
    invert_d   = wr_invert  ? wdata[WIDTH-1:0]     : invert_q;
    rise_en_d  = wr_edge_en ? wdata[WIDTH-1:0]     : rise_en_q;
    fall_en_d  = wr_edge_en ? wdata[WIDTH+15:16]   : fall_en_q;
    pend_clr   = wr_pending ? wdata[WIDTH-1:0]     : '0;
    pend_set   = (rise_evt & rise_en_q) | (fall_evt & fall_en_q);
    pending_d  = (pending_q & ~pend_clr) | pend_set;
  end

  // Control/status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      invert_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pending_q <= '0;
    end else begin
      invert_q  <= invert_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pending_q <= pending_d;
    end
  end

  // Interrupt follows the pending flags one edge after they change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pending_q;
    end
  end

  // Combinational read mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      AddrInvert:  rdata[WIDTH-1:0] = invert_q;
      AddrState:   rdata[WIDTH-1:0] = stable_q;
      AddrEdgeEn: begin
        rdata[WIDTH-1:0]    = rise_en_q;
        rdata[WIDTH+15:16]  = fall_en_q;
      end
      AddrPending: rdata[WIDTH-1:0] = pending_q;
      default:     rdata = '0;
    endcase
  end

  assign state_o = stable_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_input_controller.sv
// Scoreboard bench for gpio_input_controller (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_gpio_input_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  pin_in;
  logic [1:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  state_o;
  logic        irq;

  gpio_input_controller #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .pin_in (pin_in),
    .addr   (addr),
    .wr_en  (wr_en),
    .wdata  (wdata),
    .rdata  (rdata),
    .state_o(state_o),
    .irq    (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  // Count edges until the masked state reaches target, bounded by max_n.
  task automatic wait_state(input logic [7:0] mask, input logic [7:0] target,
                            input int max_n, output int n);
    n = 0;
    while (((state_o & mask) != target) && (n < max_n)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          n;

    reset  = 1'b1;
    pin_in = '0;
    addr   = '0;
    wr_en  = 1'b0;
    wdata  = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();

    // Quiet after reset.
    check_val("rst_state", 32'(state_o), 32'h0);
    bus_read(2'd1, r);
    check_val("rst_rd_state", r, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);
    bus_read(2'd3, r);
    check_val("rst_pend", r, 32'h0);

    // Rise on pin 0 with rise enable: 6 edges of latency, irq one edge later.
    bus_write(2'd2, 32'h0000_0001);
    bus_read(2'd2, r);
    check_val("edge_en_rb", r, 32'h1);
    pin_in = 8'h01;
    sb_push("rise_lat", 32'd6);
    sb_push("rise_pend", 32'h01);
    sb_push("rise_irq_early", 32'h0);
    sb_push("rise_irq", 32'h1);
    wait_state(8'h01, 8'h01, 20, n);
    sb_pop_check(32'(n));
    bus_read(2'd3, r);
    sb_pop_check(r);
    sb_pop_check(32'(irq));
    tick();
    sb_pop_check(32'(irq));
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, r);
    check_val("rise_clr", r, 32'h0);

    // Three-cycle glitch on pin 3 must be filtered.
    bus_write(2'd2, 32'h0008_0009);
    pin_in = 8'h09;
    repeat (3) tick();
    pin_in = 8'h01;
    repeat (12) tick();
    check_val("glitch_state", 32'(state_o), 32'h01);
    bus_read(2'd3, r);
    check_val("glitch_pend", r, 32'h0);

    // Four-cycle pulse on pin 3 passes, then release is debounced.
    pin_in = 8'h09;
    repeat (4) tick();
    pin_in = 8'h01;
    sb_push("pulse_rise", 32'h09);
    wait_state(8'h08, 8'h08, 20, n);
    sb_pop_check(32'(state_o));
    sb_push("pulse_fall", 32'h01);
    wait_state(8'h08, 8'h00, 20, n);
    sb_pop_check(32'(state_o));
    sb_push("pulse_pend", 32'h08);
    bus_read(2'd3, r);
    sb_pop_check(r);
    bus_write(2'd3, 32'hFF);
    repeat (2) tick();
    check_val("pend_clr_irq", 32'(irq), 32'h0);

    // Inversion of pin 7 debounced like a pin change.
    pin_in = 8'h00;
    repeat (10) tick();
    check_val("pins_low_state", 32'(state_o), 32'h0);
    bus_write(2'd2, 32'h0000_0080);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd0, 32'hABCD_0080);
    sb_push("inv_lat", 32'd4);
    wait_state(8'h80, 8'h80, 20, n);
    sb_pop_check(32'(n));
    bus_read(2'd0, r);
    check_val("inv_rb_mask", r, 32'h80);
    bus_read(2'd3, r);
    check_val("inv_pend", r, 32'h80);
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, r);
    check_val("state_ro", r, 32'h80);
    bus_write(2'd3, 32'h80);
    bus_read(2'd3, r);
    check_val("inv_pend_clr", r, 32'h0);
    bus_write(2'd2, 32'h0080_0000);
    bus_read(2'd2, r);
    check_val("fall_en_rb", r, 32'h0080_0000);
    bus_write(2'd0, 32'h0);
    sb_push("uninv_state", 32'h00);
    sb_push("uninv_pend", 32'h80);
    wait_state(8'h80, 8'h00, 20, n);
    sb_pop_check(32'(state_o));
    bus_read(2'd3, r);
    sb_pop_check(r);

    // Clear coinciding with a new enabled rise: set wins.
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h0000_0001);
    pin_in = 8'h01;
    wait_state(8'h01, 8'h01, 20, n);
    tick();
    pin_in = 8'h00;
    wait_state(8'h01, 8'h00, 20, n);
    repeat (2) tick();
    bus_read(2'd3, r);
    check_val("setwin_pre_pend", r, 32'h1);
    pin_in = 8'h01;
    repeat (5) tick();
    addr  = 2'd3;
    wdata = 32'h1;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check_val("setwin_align", 32'(state_o), 32'h01);
    bus_read(2'd3, r);
    check_val("setwin_pend", r, 32'h1);
    check_val("setwin_irq", 32'(irq), 32'h1);
    tick();
    check_val("setwin_irq2", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, r);
    check_val("final_clr_pend", r, 32'h0);
    tick();
    check_val("final_clr_irq", 32'(irq), 32'h0);

    // Asynchronous reset in the middle of pin 2's debounce.
    pin_in = 8'h05;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check_val("arst_state", 32'(state_o), 32'h0);
    check_val("arst_irq", 32'(irq), 32'h0);
    bus_read(2'd0, r);
    check_val("arst_inv", r, 32'h0);
    bus_read(2'd2, r);
    check_val("arst_edge_en", r, 32'h0);
    bus_read(2'd3, r);
    check_val("arst_pend", r, 32'h0);
    pin_in = 8'h00;
    tick();
    reset = 1'b0;
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, r);
    check_val("edge_en_mask", r, 32'h00FF_00FF);
    repeat (20) tick();
    check_val("post_rst_state", 32'(state_o), 32'h0);
    bus_read(2'd3, r);
    check_val("post_rst_pend", r, 32'h0);
    check_val("post_rst_irq", 32'(irq), 32'h0);

    // A pin that does differ after reset still produces its event.
    pin_in = 8'h04;
    sb_push("post_rst_rise_lat", 32'd6);
    sb_push("post_rst_rise_pend", 32'h04);
    wait_state(8'h04, 8'h04, 20, n);
    sb_pop_check(32'(n));
    bus_read(2'd3, r);
    sb_pop_check(r);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
